controlador_memoria: RTL and testbench

Responder side of the processor's unified-memory interface. It accepts instruction-fetch requests from the IF stage and data load/store requests from the MEM stage, arbitrates between them, and drives a single synchronous memory block with fixed read latency. It returns read data with a one-cycle valid pulse and raises `ocupado` so the pipeline can hold `PCescreve` low while an access is in flight.

---
 rtl/controlador_memoria_if.sv | 27 ++
 rtl/controlador_memoria.sv | 113 +++++++++++
 tb/tb_controlador_memoria.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/controlador_memoria_if.sv
// Pipeline-side bundle of the unified-memory controller: IF-stage fetch channel,
// MEM-stage load/store channel and the shared busy flag.
interface controlador_memoria_if;
    logic        req_instr;
    logic [31:0] end_instr;
    logic        instr_valida;
    logic [31:0] instr_dado;

    logic        req_dado;
    logic        escreve_dado;
    logic [31:0] end_dado;
    logic [31:0] dado_escrita;
    logic        dado_valido;
    logic [31:0] dado_lido;

    logic        ocupado;

    modport master (
        output req_instr, end_instr, req_dado, escreve_dado, end_dado, dado_escrita,
        input  instr_valida, instr_dado, dado_valido, dado_lido, ocupado
    );

    modport slave (
        input  req_instr, end_instr, req_dado, escreve_dado, end_dado, dado_escrita,
        output instr_valida, instr_dado, dado_valido, dado_lido, ocupado
    );
endinterface

// File: rtl/controlador_memoria.sv
// Unified-memory responder: arbitrates fetch vs. load/store (data first) and
// drives one synchronous memory with a fixed read latency of LATENCIA cycles.
module controlador_memoria #(
    parameter int LARGURA_END = 8,
    parameter int LATENCIA    = 2
) (
    input  logic                      clock,
    input  logic                      reset_n,
    controlador_memoria_if.slave      cpu,
    output logic [LARGURA_END-1:0]    mem_endereco,
    output logic                      mem_escreve,
    output logic [31:0]               mem_dado_escrita,
    input  logic [31:0]               mem_dado_lido
);

    localparam int LARG_CONT = $clog2(LATENCIA + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LEITURA = 2'd1,
        ESCRITA = 2'd2
    } estado_t;

    estado_t                 estado_q;
    logic [LARG_CONT-1:0]    contador_q;
    logic                    fonte_dado_q;
    logic [LARGURA_END-1:0]  mem_endereco_q;
    logic                    mem_escreve_q;
    logic [31:0]             mem_dado_escrita_q;
    logic                    instr_valida_q;
    logic [31:0]             instr_dado_q;
    logic                    dado_valido_q;
    logic [31:0]             dado_lido_q;

    // NOTE: the reset branch sits in the sensitivity list, so mem_escreve and the
    // state drop the moment reset_n falls, aborting any access without a pulse.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado_q           <= IDLE;
            contador_q         <= '0;
            fonte_dado_q       <= 1'b0;
            mem_endereco_q     <= '0;
            mem_escreve_q      <= 1'b0;
            mem_dado_escrita_q <= '0;
            instr_valida_q     <= 1'b0;
            instr_dado_q       <= '0;
            dado_valido_q      <= 1'b0;
            dado_lido_q        <= '0;
        end else begin
            // NOTE: nonblocking assignments throughout, so every branch below sees
            // the pre-edge register values regardless of statement order.
            instr_valida_q <= 1'b0;
            dado_valido_q  <= 1'b0;

            unique case (estado_q)
                IDLE: begin
                    if (cpu.req_dado) begin
                        mem_endereco_q     <= cpu.end_dado[LARGURA_END+1:2];
                        mem_dado_escrita_q <= cpu.dado_escrita;
                        fonte_dado_q       <= 1'b1;
                        if (cpu.escreve_dado) begin
                            mem_escreve_q <= 1'b1;
                            estado_q      <= ESCRITA;
                        end else begin
                            contador_q <= LARG_CONT'(LATENCIA - 1);
                            estado_q   <= LEITURA;
                        end
                    end else if (cpu.req_instr) begin
                        mem_endereco_q <= cpu.end_instr[LARGURA_END+1:2];
                        fonte_dado_q   <= 1'b0;
                        contador_q     <= LARG_CONT'(LATENCIA - 1);
                        estado_q       <= LEITURA;
                    end
                end

                LEITURA: begin
                    // The counter hits zero on the edge where the memory output is valid.
                    if (contador_q == '0) begin
                        if (fonte_dado_q) begin
                            dado_lido_q   <= mem_dado_lido;
                            dado_valido_q <= 1'b1;
                        end else begin
                            instr_dado_q   <= mem_dado_lido;
                            instr_valida_q <= 1'b1;
                        end
                        estado_q <= IDLE;
                    end else begin
                        contador_q <= contador_q - LARG_CONT'(1);
                    end
                end

                ESCRITA: begin
                    mem_escreve_q <= 1'b0;
                    dado_valido_q <= 1'b1;
                    estado_q      <= IDLE;
                end

                default: estado_q <= IDLE;
            endcase
        end
    end

    assign mem_endereco     = mem_endereco_q;
    assign mem_escreve      = mem_escreve_q;
    assign mem_dado_escrita = mem_dado_escrita_q;

    assign cpu.instr_valida = instr_valida_q;
    assign cpu.instr_dado   = instr_dado_q;
    assign cpu.dado_valido  = dado_valido_q;
    assign cpu.dado_lido    = dado_lido_q;
    assign cpu.ocupado      = (estado_q != IDLE);

endmodule

// File: tb/tb_controlador_memoria.sv
// Scoreboard bench for controlador_memoria: main instance at LATENCIA=2 plus
// fetch-only sweep instances at LATENCIA=1 and 4.
module tb_controlador_memoria;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    localparam int LM = 2;

    logic clock = 1'b0;
    logic reset_n;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Main instance, LATENCIA = 2, with a one-register-stage memory model.
    controlador_memoria_if bus_m ();
    logic [7:0]  mem_end_m;
    logic        mem_esc_m;
    logic [31:0] mem_wd_m;
    logic [31:0] mem_rd_m;
    logic [31:0] mem_m [256];
    logic [31:0] pipe_m;

    controlador_memoria #(.LARGURA_END(8), .LATENCIA(LM)) dut_m (
        .clock            (clock),
        .reset_n          (reset_n),
        .cpu              (bus_m),
        .mem_endereco     (mem_end_m),
        .mem_escreve      (mem_esc_m),
        .mem_dado_escrita (mem_wd_m),
        .mem_dado_lido    (mem_rd_m)
    );

    always @(posedge clock) if (mem_esc_m) mem_m[mem_end_m] = mem_wd_m;
    always @(posedge clock) pipe_m <= mem_m[mem_end_m];
    assign mem_rd_m = pipe_m;

    exp_t        q_i[$];
    exp_t        q_d[$];
    logic [31:0] last_load = 32'h0;

    always @(negedge clock) begin
        exp_t e;
        if (reset_n) begin
            if (bus_m.instr_valida) begin
                if (q_i.size() == 0) check("instr_spurious", bus_m.instr_valida, 1'b0);
                else begin
                    e = q_i.pop_front();
                    check("instr_data", bus_m.instr_dado, e.data);
                    check("instr_cycle", cyc, e.cyc);
                end
            end
            if (bus_m.dado_valido) begin
                if (q_d.size() == 0) check("data_spurious", bus_m.dado_valido, 1'b0);
                else begin
                    e = q_d.pop_front();
                    check("data_value", bus_m.dado_lido, e.data);
                    check("data_cycle", cyc, e.cyc);
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_instr_valida"}, bus_m.instr_valida, 0);
        check({tag, "_instr_dado"}, bus_m.instr_dado, 0);
        check({tag, "_dado_valido"}, bus_m.dado_valido, 0);
        check({tag, "_dado_lido"}, bus_m.dado_lido, 0);
        check({tag, "_ocupado"}, bus_m.ocupado, 0);
        check({tag, "_mem_endereco"}, mem_end_m, 0);
        check({tag, "_mem_escreve"}, mem_esc_m, 0);
        check({tag, "_mem_dado_escrita"}, mem_wd_m, 0);
    endtask

    // Called at #1 after an edge; returns at #1 after the edge that raised instr_valida.
    task automatic fetch_op(input logic [31:0] addr, input logic [31:0] word, input int extra);
        exp_t e;
        int   w;
        bus_m.req_instr = 1'b1;
        bus_m.end_instr = addr;
        e.data = word;
        e.cyc  = cyc + 1 + LM + extra;
        q_i.push_back(e);
        w = 0;
        do begin
            @(posedge clock); #1; w++;
        end while (!bus_m.instr_valida && w < 30);
        if (!bus_m.instr_valida) check("fetch_timeout", bus_m.instr_valida, 1'b1);
        bus_m.req_instr = 1'b0;
    endtask

    task automatic data_op(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rd_word, input int extra);
        exp_t e;
        int   w;
        bus_m.req_dado     = 1'b1;
        bus_m.escreve_dado = wr;
        bus_m.end_dado     = addr;
        bus_m.dado_escrita = wdata;
        if (!wr) last_load = rd_word;
        e.data = last_load;
        e.cyc  = wr ? cyc + 2 + extra : cyc + 1 + LM + extra;
        q_d.push_back(e);
        w = 0;
        do begin
            @(posedge clock); #1; w++;
        end while (!bus_m.dado_valido && w < 30);
        if (!bus_m.dado_valido) check("data_timeout", bus_m.dado_valido, 1'b1);
        bus_m.req_dado     = 1'b0;
        bus_m.escreve_dado = 1'b0;
    endtask

    initial begin
        reset_n            = 1'b0;
        bus_m.req_instr    = 1'b0;
        bus_m.end_instr    = '0;
        bus_m.req_dado     = 1'b0;
        bus_m.escreve_dado = 1'b0;
        bus_m.end_dado     = '0;
        bus_m.dado_escrita = '0;
        mem_m[5]  = 32'h8C22_0004;
        mem_m[16] = 32'h1111_2222;
        mem_m[17] = 32'h3333_4444;

        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            bus_m.req_instr    = 1'($urandom);
            bus_m.end_instr    = $urandom;
            bus_m.req_dado     = 1'($urandom);
            bus_m.escreve_dado = 1'($urandom);
            bus_m.end_dado     = $urandom;
            bus_m.dado_escrita = $urandom;
        end
        @(negedge clock);
        check_all_zero("reset");
        bus_m.req_instr = 1'b0;
        bus_m.req_dado  = 1'b0;
        bus_m.escreve_dado = 1'b0;
        @(posedge clock); #1 reset_n = 1'b1;
        repeat (3) @(posedge clock);
        #1 check("idle_ocupado", bus_m.ocupado, 1'b0);

        // Fetch from 0x14 (word 5), cycle by cycle.
        bus_m.req_instr = 1'b1;
        bus_m.end_instr = 32'h14;
        q_i.push_back('{32'h8C22_0004, cyc + 3});
        @(posedge clock); #1;
        check("fetch_mem_endereco", mem_end_m, 8'd5);
        check("fetch_ocupado_1", bus_m.ocupado, 1'b1);
        check("fetch_valida_early1", bus_m.instr_valida, 1'b0);
        @(posedge clock); #1;
        check("fetch_ocupado_2", bus_m.ocupado, 1'b1);
        check("fetch_valida_early2", bus_m.instr_valida, 1'b0);
        @(posedge clock); #1;
        check("fetch_valida", bus_m.instr_valida, 1'b1);
        check("fetch_ocupado_done", bus_m.ocupado, 1'b0);
        bus_m.req_instr = 1'b0;
        @(posedge clock); #1;
        check("fetch_valida_pulse", bus_m.instr_valida, 1'b0);

        // Store 0xDEADBEEF to 0x20 (word 8), cycle by cycle.
        bus_m.req_dado     = 1'b1;
        bus_m.escreve_dado = 1'b1;
        bus_m.end_dado     = 32'h20;
        bus_m.dado_escrita = 32'hDEAD_BEEF;
        q_d.push_back('{last_load, cyc + 2});
        @(posedge clock); #1;
        check("store_mem_escreve", mem_esc_m, 1'b1);
        check("store_mem_endereco", mem_end_m, 8'd8);
        check("store_mem_dado", mem_wd_m, 32'hDEAD_BEEF);
        check("store_valido_early", bus_m.dado_valido, 1'b0);
        @(posedge clock); #1;
        check("store_escreve_drop", mem_esc_m, 1'b0);
        check("store_valido", bus_m.dado_valido, 1'b1);
        bus_m.req_dado     = 1'b0;
        bus_m.escreve_dado = 1'b0;
        @(posedge clock); #1;
        check("store_valido_pulse", bus_m.dado_valido, 1'b0);

        // Load from 0x23: byte offset ignored, hits word 8.
        data_op(1'b0, 32'h23, 32'h0, 32'hDEAD_BEEF, 0);
        check("load_instr_dado_kept", bus_m.instr_dado, 32'h8C22_0004);

        // Upper address bits ignored: 0x12345417 -> word 5.
        fetch_op(32'h1234_5417, 32'h8C22_0004, 0);

        // Simultaneous requests: data first, fetch waits LM+1 extra cycles.
        fork
            data_op(1'b0, 32'h40, 32'h0, 32'h1111_2222, 0);
            fetch_op(32'h44, 32'h3333_4444, LM + 1);
        join

        // Back-to-back store and load on word 6.
        data_op(1'b1, 32'h18, 32'h55AA_55AA, 32'h0, 0);
        data_op(1'b0, 32'h18, 32'h0, 32'h55AA_55AA, 0);

        // Reset one cycle into a fetch: everything clears, no pulse afterwards.
        bus_m.req_instr = 1'b1;
        bus_m.end_instr = 32'h18;
        @(posedge clock); #1;
        check("abort_ocupado", bus_m.ocupado, 1'b1);
        check("abort_escreve_pre", mem_esc_m, 1'b0);
        #2 reset_n = 1'b0;
        #1 check_all_zero("abort");
        bus_m.req_instr = 1'b0;
        last_load = 32'h0;
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        repeat (6) @(posedge clock);
        #1 check("abort_idle", bus_m.ocupado, 1'b0);
        check("abort_no_valid", bus_m.instr_valida, 1'b0);

        fetch_op(32'h14, 32'h8C22_0004, 0);

        while (cyc < 300) @(posedge clock);
        #1;
        check("instr_queue_empty", q_i.size(), 0);
        check("data_queue_empty", q_d.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Sweep: eight back-to-back fetches at LATENCIA = 1 and 4.
    for (genvar gi = 0; gi < 2; gi++) begin : g_sweep
        localparam int LS = (gi == 0) ? 1 : 4;

        controlador_memoria_if sb ();
        logic        rst_s;
        logic [7:0]  end_s;
        logic        esc_s;
        logic [31:0] wd_s;
        logic [31:0] rd_s;
        logic [31:0] mem_s [256];
        logic [31:0] pipe_s [4];
        exp_t        q_s[$];
        exp_t        e_s;

        controlador_memoria #(.LARGURA_END(8), .LATENCIA(LS)) dut_s (
            .clock            (clock),
            .reset_n          (rst_s),
            .cpu              (sb),
            .mem_endereco     (end_s),
            .mem_escreve      (esc_s),
            .mem_dado_escrita (wd_s),
            .mem_dado_lido    (rd_s)
        );

        always @(posedge clock) begin
            pipe_s[0] <= mem_s[end_s];
            for (int k = 1; k < 4; k++) pipe_s[k] <= pipe_s[k-1];
        end

        if (LS == 1) begin : g_comb
            assign rd_s = mem_s[end_s];
        end else begin : g_pipe
            assign rd_s = pipe_s[LS-2];
        end

        always @(negedge clock) begin
            if (rst_s && sb.instr_valida) begin
                if (q_s.size() == 0) check($sformatf("sweep_L%0d_spurious", LS), sb.instr_valida, 1'b0);
                else begin
                    e_s = q_s.pop_front();
                    check($sformatf("sweep_L%0d_data", LS), sb.instr_dado, e_s.data);
                    check($sformatf("sweep_L%0d_cycle", LS), cyc, e_s.cyc);
                end
            end
        end

        initial begin
            int c0;
            int w;
            rst_s           = 1'b0;
            sb.req_instr    = 1'b0;
            sb.end_instr    = '0;
            sb.req_dado     = 1'b0;
            sb.escreve_dado = 1'b0;
            sb.end_dado     = '0;
            sb.dado_escrita = '0;
            for (int i = 0; i < 8; i++) mem_s[i+3] = 32'hC0DE_0000 + 32'(LS << 8) + 32'(i);
            repeat (3) @(posedge clock);
            #1 rst_s = 1'b1;
            @(posedge clock); #1;
            c0 = cyc;
            for (int i = 0; i < 8; i++)
                q_s.push_back('{32'hC0DE_0000 + 32'(LS << 8) + 32'(i), c0 + 1 + LS + i * (LS + 1)});
            sb.req_instr = 1'b1;
            sb.end_instr = 32'(3 * 4);
            for (int n = 0; n < 8; n++) begin
                w = 0;
                do begin
                    @(posedge clock); #1; w++;
                end while (!sb.instr_valida && w < 20);
                if (!sb.instr_valida) check($sformatf("sweep_L%0d_timeout", LS), sb.instr_valida, 1'b1);
                if (n < 7) sb.end_instr = 32'((n + 4) * 4);
                else       sb.req_instr = 1'b0;
            end
            repeat (3) @(posedge clock);
            #1 check($sformatf("sweep_L%0d_pending", LS), q_s.size(), 0);
        end
    end

endmodule
